// File: rtl/mem_bus_resp.sv
// mem_bus_resp: memory-side responder for the shared CPU memory bus.
// 256-byte space: RAM everywhere except two memory-mapped I/O bytes
// (output latch at 8'hFF, synchronized input port at 8'hFE).
module mem_bus_resp (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_re_,
  input  logic       mem_we_,
  input  logic [7:0] abus,
  inout  wire  [7:0] dbus,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       bus_err
);

  localparam logic [7:0] IO_OUT_ADDR = 8'hFF;
  localparam logic [7:0] IO_IN_ADDR  = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [7:0] mem_r [0:255];
  logic [7:0] rdata_r;
  logic [7:0] sync1_r;
  logic [7:0] sync2_r;
  logic [7:0] io_out_r;
  logic       bus_err_r;
  logic [7:0] rd_mux_s;
  logic       re_s;
  logic       we_s;
  logic       do_read_s;
  logic       do_write_s;
  logic       set_err_s;
  logic       drive_en_s;
  logic       ram_sel_s;

  // Strobes are open-drain: only a driven 0 means asserted.
  assign re_s = (mem_re_ == 1'b0);
  assign we_s = (mem_we_ == 1'b0);

  assign ram_sel_s = (abus != IO_OUT_ADDR) && (abus != IO_IN_ADDR);

  // Next-state and strobe decode; every state shares the same entry rules,
  // so a strobe change moves straight between RD and WR without an IDLE gap.
  always_comb begin
    state_s    = ST_IDLE;
    do_read_s  = 1'b0;
    do_write_s = 1'b0;
    set_err_s  = 1'b0;
    if (bus_err_r) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_RD, ST_WR: begin
          if (re_s && we_s) begin
            state_s   = ST_IDLE;
            set_err_s = 1'b1;
          end else if (re_s) begin
            state_s   = ST_RD;
            do_read_s = 1'b1;
          end else if (we_s) begin
            state_s    = ST_WR;
            do_write_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Read-data source selection by address.
  always_comb begin
    rd_mux_s = 8'h00;
    case (abus)
      IO_OUT_ADDR: rd_mux_s = io_out_r;
      IO_IN_ADDR:  rd_mux_s = sync2_r;
      default:     rd_mux_s = mem_r[abus];
    endcase
  end

  // Control state, read latch, output latch, error flag and input synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rdata_r   <= 8'h00;
      io_out_r  <= 8'h00;
      bus_err_r <= 1'b0;
      sync1_r   <= 8'h00;
      sync2_r   <= 8'h00;
    end else begin
      state_r <= state_s;
      sync1_r <= io_in;
      sync2_r <= sync1_r;
      if (set_err_s) begin
        bus_err_r <= 1'b1;
      end
      if (do_read_s) begin
        rdata_r <= rd_mux_s;
      end
      if (do_write_s && (abus == IO_OUT_ADDR)) begin
        io_out_r <= dbus;
      end
    end
  end

  // RAM array: never reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && do_write_s && ram_sel_s) begin
      mem_r[abus] <= dbus;
    end
  end

  // Drive only while the read strobe is still low, so release is immediate.
  assign drive_en_s = (state_r == ST_RD) && re_s && !bus_err_r;
  assign dbus       = drive_en_s ? rdata_r : 8'bzzzz_zzzz;

  assign io_out  = io_out_r;
  assign bus_err = bus_err_r;

endmodule

// File: tb/tb_mem_bus_resp.sv
// Self-checking bench for mem_bus_resp: directed scenarios followed by
// randomized traffic, compared against a transaction-level reference model.
module tb_mem_bus_resp;

  logic       clk;
  logic       rst;
  logic       mem_re_;
  logic       mem_we_;
  logic [7:0] abus;
  wire  [7:0] dbus;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic       bus_err;
  logic [7:0] drv_d;
  logic       drv_oe;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  logic [7:0] ram_m [256];
  bit         known_m [256];
  logic [7:0] out_m;
  bit         err_m;
  bit         rdv_m;
  bit         rdk_m;
  logic [7:0] rdd_m;
  logic [7:0] s1_m;
  logic [7:0] s2_m;

  // Undriven bus floats high so a released bus reads as 8'hFF.
  pullup (dbus);
  assign dbus = drv_oe ? drv_d : 8'bzzzz_zzzz;

  mem_bus_resp dut (
    .clk     (clk),
    .rst     (rst),
    .mem_re_ (mem_re_),
    .mem_we_ (mem_we_),
    .abus    (abus),
    .dbus    (dbus),
    .io_in   (io_in),
    .io_out  (io_out),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One bus cycle: drive, check bus before the edge, update model, check latches.
  task automatic step(input logic r_n, input logic w_n, input logic [7:0] a,
                      input logic [7:0] d, input logic rs, input logic [7:0] ioi);
    mem_re_ = r_n;
    mem_we_ = w_n;
    abus    = a;
    drv_d   = d;
    drv_oe  = !w_n;
    rst     = rs;
    io_in   = ioi;
    #2;
    if (w_n) begin
      if (rdv_m && !r_n && !err_m) begin
        if (rdk_m) chk("dbus_rd", dbus, rdd_m);
      end else begin
        chk("dbus_z", dbus, 8'hFF);
      end
    end
    @(posedge clk);
    if (rs) begin
      out_m = 8'h00; err_m = 1'b0; rdv_m = 1'b0; rdd_m = 8'h00; rdk_m = 1'b1;
      s1_m = 8'h00; s2_m = 8'h00;
    end else begin
      if (err_m) begin
        rdv_m = 1'b0;
      end else if (!r_n && !w_n) begin
        err_m = 1'b1;
        rdv_m = 1'b0;
      end else if (!r_n) begin
        rdv_m = 1'b1;
        rdk_m = 1'b1;
        if (a == 8'hFF) rdd_m = out_m;
        else if (a == 8'hFE) rdd_m = s2_m;
        else begin
          rdd_m = ram_m[a];
          rdk_m = known_m[a];
        end
      end else if (!w_n) begin
        rdv_m = 1'b0;
        if (a == 8'hFF) out_m = d;
        else if (a != 8'hFE) begin
          ram_m[a]   = d;
          known_m[a] = 1'b1;
        end
      end else begin
        rdv_m = 1'b0;
      end
      s2_m = s1_m;
      s1_m = ioi;
    end
    @(negedge clk);
    chk("io_out", io_out, out_m);
    chk("bus_err", {7'd0, bus_err}, {7'd0, err_m});
  endtask

  initial begin
    logic [7:0] cur_in;
    clk = 1'b0; rst = 1'b1; mem_re_ = 1'b1; mem_we_ = 1'b1;
    abus = 8'h00; drv_d = 8'h00; drv_oe = 1'b0; io_in = 8'h00;
    out_m = 8'h00; err_m = 1'b0; rdv_m = 1'b0; rdk_m = 1'b1; rdd_m = 8'h00;
    s1_m = 8'h00; s2_m = 8'h00;
    for (int i = 0; i < 256; i++) begin
      known_m[i] = 1'b0;
      ram_m[i]   = 8'h00;
    end
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00);

    // Write then two-cycle read
    step(1'b1, 1'b0, 8'h10, 8'h5A, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h11, 8'hA5, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00);

    // Back-to-back reads with changing address
    step(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00);

    // Output latch and ignored input-port write
    step(1'b1, 1'b0, 8'hFF, 8'hC3, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'hFE, 8'h77, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFE, 8'h00, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00);

    // Input synchronizer: read one edge after the change sees old data, next sees new
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'hFE, 8'h00, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'hFE, 8'h00, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'hFE, 8'h00, 1'b0, 8'h3C);
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h3C);

    // Both strobes low: sticky error, suppressed write and reads
    step(1'b0, 1'b0, 8'h10, 8'hFF, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h3C);
    step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h3C);
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h3C);
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h3C);

    // Reset during second read cycle; write coinciding with reset is dropped
    step(1'b1, 1'b0, 8'hFF, 8'hC3, 1'b0, 8'h3C);
    step(1'b1, 1'b0, 8'h12, 8'h11, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 8'h3C);
    step(1'b1, 1'b0, 8'h12, 8'h99, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h12, 8'h00, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h12, 8'h00, 1'b0, 8'h3C);
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h3C);

    // Randomized traffic (no simultaneous strobes)
    cur_in = 8'h3C;
    for (int n = 0; n < 400; n++) begin
      int op;
      int ai;
      logic [7:0] a;
      logic [7:0] d;
      logic rs;
      op = $urandom_range(0, 9);
      ai = $urandom_range(0, 9);
      if (ai < 8) a = 8'h10 + 8'(ai);
      else if (ai == 8) a = 8'hFE;
      else a = 8'hFF;
      d = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) cur_in = 8'($urandom_range(0, 255));
      if (op < 4) step(1'b0, 1'b1, a, 8'h00, rs, cur_in);
      else if (op < 7) step(1'b1, 1'b0, a, d, rs, cur_in);
      else step(1'b1, 1'b1, a, 8'h00, rs, cur_in);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
